// File: rtl/add64_seq.sv
// -----------------------------------------------------------------------------
// add64_seq
// Sequential 64-bit add/subtract built on a shared, external 32-bit adder.
// A request is accepted in IDLE, the low half is added in LO, the high half
// (with the low-half carry) in HI, and the result is presented in DONE until
// the downstream side accepts it.
//
// Ports
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_valid / o_ready        request handshake (o_ready = 1 only in IDLE)
//   i_a, i_b, i_sub          operands; i_sub = 1 selects A - B
//   o_valid / i_ready        result handshake (o_valid = 1 only in DONE)
//   o_sum, o_cout, o_ovf     result, carry out (no-borrow for subtract),
//                            signed overflow
//   o_add_a, o_add_b,
//   o_add_cin                operands driven to the external 32-bit adder
//   i_add_s, i_add_cout      combinational result of the external adder
// -----------------------------------------------------------------------------
module add64_seq (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [63:0] i_a,
   input  logic [63:0] i_b,
   input  logic        i_sub,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [63:0] o_sum,
   output logic        o_cout,
   output logic        o_ovf,
   output logic [31:0] o_add_a,
   output logic [31:0] o_add_b,
   output logic        o_add_cin,
   input  logic [31:0] i_add_s,
   input  logic        i_add_cout
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LO   = 2'd1,
      S_HI   = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_next;

   logic [63:0] r_a;
   logic [63:0] r_beff;
   logic        r_sub;
   logic        r_carry_mid;
   logic [63:0] r_sum;
   logic        r_cout;
   logic        r_ovf;

   logic        w_accept;

   assign o_ready  = (r_state == S_IDLE);
   assign o_valid  = (r_state == S_DONE);
   assign w_accept = o_ready & i_valid;

   assign o_sum    = r_sum;
   assign o_cout   = r_cout;
   assign o_ovf    = r_ovf;

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next state and adder operand steering; adder inputs are zero outside LO/HI
   always_comb begin
      w_next    = r_state;
      o_add_a   = '0;
      o_add_b   = '0;
      o_add_cin = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_valid) w_next = S_LO;
         end
         S_LO: begin
            o_add_a   = r_a[31:0];
            o_add_b   = r_beff[31:0];
            // Subtract is A + ~B + 1: the +1 enters as the low-half carry-in
            o_add_cin = r_sub;
            w_next    = S_HI;
         end
         S_HI: begin
            o_add_a   = r_a[63:32];
            o_add_b   = r_beff[63:32];
            o_add_cin = r_carry_mid;
            w_next    = S_DONE;
         end
         S_DONE: begin
            if (i_ready) w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Operand capture and result accumulation
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_a         <= '0;
         r_beff      <= '0;
         r_sub       <= 1'b0;
         r_carry_mid <= 1'b0;
         r_sum       <= '0;
         r_cout      <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_a    <= i_a;
                  r_beff <= i_b ^ {64{i_sub}};
                  r_sub  <= i_sub;
               end
            end
            S_LO: begin
               r_sum[31:0] <= i_add_s;
               r_carry_mid <= i_add_cout;
            end
            S_HI: begin
               r_sum[63:32] <= i_add_s;
               r_cout       <= i_add_cout;
               // Overflow: both addends share a sign that the result does not
               r_ovf        <= (r_a[63] == r_beff[63]) && (i_add_s[31] != r_a[63]);
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_add64_seq.sv
module tb_add64_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_valid;
   logic        o_ready;
   logic [63:0] i_a;
   logic [63:0] i_b;
   logic        i_sub;
   logic        o_valid;
   logic        i_ready;
   logic [63:0] o_sum;
   logic        o_cout;
   logic        o_ovf;
   logic [31:0] add_a;
   logic [31:0] add_b;
   logic        add_cin;
   logic [31:0] add_s;
   logic        add_cout;

   always #5 clk = ~clk;

   // Behavioural stand-in for the shared external 32-bit adder
   assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

   add64_seq dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .i_a        (i_a),
      .i_b        (i_b),
      .i_sub      (i_sub),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_sum      (o_sum),
      .o_cout     (o_cout),
      .o_ovf      (o_ovf),
      .o_add_a    (add_a),
      .o_add_b    (add_b),
      .o_add_cin  (add_cin),
      .i_add_s    (add_s),
      .i_add_cout (add_cout)
   );

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic        sub;
      logic [63:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   typedef struct {
      logic [63:0] sum;
      logic        cout;
      logic        ovf;
   } exp_t;

   exp_t        sb_q[$];
   int          checks   = 0;
   int          failures = 0;
   longint      cyc      = 0;
   bit          b2b      = 1'b0;

   // monitor state
   bit          in_flight  = 1'b0;
   bit          prev_valid = 1'b0;
   longint      acc_cyc    = 0;
   longint      last_acc   = -1;
   logic [63:0] acc_a;
   logic [63:0] acc_be;
   logic        acc_sub;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%h required=0x%h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: true 65-bit arithmetic, overflow from operand/result signs
   function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic sub);
      exp_t        e;
      logic [64:0] r;
      if (sub) r = {1'b0, a} + {1'b0, ~b} + 65'd1;
      else     r = {1'b0, a} + {1'b0, b};
      e.sum  = r[63:0];
      e.cout = r[64];
      if (sub) e.ovf = (a[63] != b[63]) && (r[63] != a[63]);
      else     e.ovf = (a[63] == b[63]) && (r[63] != a[63]);
      return e;
   endfunction

   // Monitor / scoreboard, sampling on the falling edge
   always @(negedge clk) begin
      longint      phase;
      logic [32:0] low;
      exp_t        e;
      if (!rst_n) begin
         chk("rst_valid", {63'd0, o_valid}, 64'd0);
         chk("rst_sum",   o_sum,            64'd0);
         chk("rst_cout",  {63'd0, o_cout},  64'd0);
         chk("rst_ovf",   {63'd0, o_ovf},   64'd0);
         in_flight  = 1'b0;
         prev_valid = 1'b0;
         last_acc   = -1;
      end else begin
         if (!b2b) last_acc = -1;
         if (in_flight && !o_valid && !o_ready) begin
            phase = cyc - acc_cyc;
            low   = {1'b0, acc_a[31:0]} + {1'b0, acc_be[31:0]} + {32'd0, acc_sub};
            if (phase == 1) begin
               chk("lo_add_a",   {32'd0, add_a},   {32'd0, acc_a[31:0]});
               chk("lo_add_b",   {32'd0, add_b},   {32'd0, acc_be[31:0]});
               chk("lo_add_cin", {63'd0, add_cin}, {63'd0, acc_sub});
            end else if (phase == 2) begin
               chk("hi_add_a",   {32'd0, add_a},   {32'd0, acc_a[63:32]});
               chk("hi_add_b",   {32'd0, add_b},   {32'd0, acc_be[63:32]});
               chk("hi_add_cin", {63'd0, add_cin}, {63'd0, low[32]});
            end else begin
               chk("busy_phase", phase[63:0], 64'd2);
            end
         end
         if (o_ready) begin
            chk("idle_add_a",   {32'd0, add_a},   64'd0);
            chk("idle_add_b",   {32'd0, add_b},   64'd0);
            chk("idle_add_cin", {63'd0, add_cin}, 64'd0);
            chk("idle_valid",   {63'd0, o_valid}, 64'd0);
         end
         if (o_valid) begin
            chk("done_add_a", {32'd0, add_a},   64'd0);
            chk("done_add_b", {32'd0, add_b},   64'd0);
            chk("done_ready", {63'd0, o_ready}, 64'd0);
            if (!prev_valid) chk("latency", cyc - acc_cyc, 64'd3);
            if (i_ready) begin
               if (sb_q.size() == 0) begin
                  chk("unexpected_result", 64'd1, 64'd0);
               end else begin
                  e = sb_q.pop_front();
                  chk("sum",  o_sum,           e.sum);
                  chk("cout", {63'd0, o_cout}, {63'd0, e.cout});
                  chk("ovf",  {63'd0, o_ovf},  {63'd0, e.ovf});
               end
               in_flight = 1'b0;
            end
         end
         if (i_valid && o_ready) begin
            if (last_acc >= 0) chk("interval", cyc - last_acc, 64'd4);
            last_acc  = cyc;
            acc_cyc   = cyc;
            acc_a     = i_a;
            acc_be    = i_b ^ {64{i_sub}};
            acc_sub   = i_sub;
            in_flight = 1'b1;
         end
         prev_valid = o_valid;
      end
   end

   // Issue one request; entered and left at posedge+1
   task automatic req(input logic [63:0] a, input logic [63:0] b, input logic sub, input exp_t e);
      int n = 0;
      while (!o_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("req_ready_timeout", {63'd0, o_ready}, 64'd1);
      i_valid = 1'b1;
      i_a     = a;
      i_b     = b;
      i_sub   = sub;
      sb_q.push_back(e);
      @(posedge clk); #1;
      i_valid = 1'b0;
      i_a     = {$urandom(), $urandom()};
      i_b     = {$urandom(), $urandom()};
      i_sub   = 1'($urandom_range(0, 1));
   endtask

   task automatic drain();
      int n = 0;
      while ((sb_q.size() != 0 || !o_ready) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_pending", sb_q.size(), 64'd0);
   endtask

   vec_t vecs[8];

   initial begin
      exp_t        e;
      exp_t        eh;
      logic [63:0] ha;
      logic [63:0] hb;
      int          sent;
      int          n;

      vecs[0] = '{64'h00000000_FFFFFFFF, 64'd1, 1'b0, 64'h00000001_00000000, 1'b0, 1'b0};
      vecs[1] = '{64'h7FFFFFFF_FFFFFFFF, 64'd1, 1'b0, 64'h80000000_00000000, 1'b0, 1'b1};
      vecs[2] = '{64'd5, 64'd7, 1'b1, 64'hFFFFFFFF_FFFFFFFE, 1'b0, 1'b0};
      vecs[3] = '{64'd7, 64'd5, 1'b1, 64'd2, 1'b1, 1'b0};
      vecs[4] = '{64'hFFFFFFFF_FFFFFFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0};
      vecs[5] = '{64'h80000000_00000000, 64'd1, 1'b1, 64'h7FFFFFFF_FFFFFFFF, 1'b1, 1'b1};
      vecs[6] = '{64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0};
      vecs[7] = '{64'd0, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0};

      rst_n   = 1'b0;
      i_valid = 1'b0;
      i_ready = 1'b1;
      i_a     = '0;
      i_b     = '0;
      i_sub   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      chk("post_rst_ready", {63'd0, o_ready}, 64'd1);
      chk("post_rst_valid", {63'd0, o_valid}, 64'd0);
      @(posedge clk); #1;

      // Directed vectors
      for (int i = 0; i < 8; i++) begin
         e.sum  = vecs[i].sum;
         e.cout = vecs[i].cout;
         e.ovf  = vecs[i].ovf;
         req(vecs[i].a, vecs[i].b, vecs[i].sub, e);
      end
      drain();

      // Result held under back-pressure while new requests are offered
      ha = 64'h12345678_9ABCDEF0;
      hb = 64'h0FEDCBA9_87654321;
      eh = model(ha, hb, 1'b0);
      i_ready = 1'b0;
      req(ha, hb, 1'b0, eh);
      n = 0;
      while (!o_valid && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      chk("hold_valid_timeout", {63'd0, o_valid}, 64'd1);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         i_valid = 1'b1;
         i_a     = {$urandom(), $urandom()};
         i_b     = {$urandom(), $urandom()};
         i_sub   = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("hold_valid", {63'd0, o_valid}, 64'd1);
         chk("hold_sum",   o_sum,            eh.sum);
         chk("hold_ready", {63'd0, o_ready}, 64'd0);
      end
      @(posedge clk); #1;
      i_valid = 1'b0;
      i_ready = 1'b1;
      @(posedge clk); #1;
      chk("release_valid", {63'd0, o_valid}, 64'd0);
      chk("release_ready", {63'd0, o_ready}, 64'd1);
      chk("release_keep_sum", o_sum, eh.sum);
      drain();

      // Reset during HI aborts the operation
      req(64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0,
          model(64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0));
      @(posedge clk); #1;
      chk("pre_abort_in_hi", {32'd0, add_a}, 64'hFFFFFFFF);
      rst_n = 1'b0;
      sb_q.delete();
      #1;
      chk("abort_valid", {63'd0, o_valid}, 64'd0);
      chk("abort_sum",   o_sum,            64'd0);
      chk("abort_cout",  {63'd0, o_cout},  64'd0);
      chk("abort_ovf",   {63'd0, o_ovf},   64'd0);
      chk("abort_add_a", {32'd0, add_a},   64'd0);
      chk("abort_add_b", {32'd0, add_b},   64'd0);
      chk("abort_cin",   {63'd0, add_cin}, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk("abort_no_valid", {63'd0, o_valid}, 64'd0);
      end
      e.sum  = 64'd7;
      e.cout = 1'b0;
      e.ovf  = 1'b0;
      req(64'd3, 64'd4, 1'b0, e);
      drain();

      // Back-to-back random traffic
      b2b     = 1'b1;
      sent    = 0;
      n       = 0;
      i_ready = 1'b1;
      while (sent < 10000 && n < 50000) begin
         i_valid = 1'b1;
         i_a     = {$urandom(), $urandom()};
         i_b     = {$urandom(), $urandom()};
         i_sub   = 1'($urandom_range(0, 1));
         if (o_ready) begin
            sb_q.push_back(model(i_a, i_b, i_sub));
            sent++;
         end
         @(posedge clk); #1;
         n++;
      end
      i_valid = 1'b0;
      chk("b2b_sent", sent, 64'd10000);
      drain();
      b2b = 1'b0;
      chk("final_queue_empty", sb_q.size(), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/add64_seq.md
ADD64_SEQ -- requirements
Module: add64_seq

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_valid  input  1  upstream request valid.
REQ-005 o_ready  output  1  block can accept a request this cycle.
REQ-006 i_a  input  64  operand A.
REQ-007 i_b  input  64  operand B.
REQ-008 i_sub  input  1  0 = A+B, 1 = A-B.
REQ-009 o_valid  output  1  result valid, held until accepted.
REQ-010 i_ready  input  1  downstream accepts result.
REQ-011 o_sum  output  64  result.
REQ-012 o_cout  output  1  64-bit carry out; for subtract, 1 = no borrow.
REQ-013 o_ovf  output  1  signed two's-complement overflow.
REQ-014 o_add_a  output  32  operand A to the shared external 32-bit carry-lookahead adder.
REQ-015 o_add_b  output  32  operand B to the external adder.
REQ-016 o_add_cin  output  1  carry-in to the external adder.
REQ-017 i_add_s  input  32  external adder sum; combinational, same cycle.
REQ-018 i_add_cout  input  1  external adder carry out; combinational, same cycle.

Function
REQ-019 The FSM SHALL have four states: IDLE, LO, HI, DONE.
REQ-020 IDLE: o_ready=1; on i_valid=1, register i_a, i_b, i_sub and go to LO; otherwise stay.
REQ-021 On acceptance, the block SHALL register effective B as i_b XOR {64{i_sub}}.
REQ-022 LO: o_add_a = A[31:0], o_add_b = Beff[31:0], o_add_cin = sub; register i_add_s into sum[31:0] and i_add_cout into carry_mid; go to HI.
REQ-023 HI: o_add_a = A[63:32], o_add_b = Beff[63:32], o_add_cin = carry_mid; register i_add_s into sum[63:32] and i_add_cout into o_cout; go to DONE.
REQ-024 In HI, o_ovf SHALL be registered as (A[63] == Beff[63]) AND (i_add_s[31] != A[63]).
REQ-025 DONE: o_valid=1; o_sum, o_cout and o_ovf stable; go to IDLE when i_ready=1, else stay.
REQ-026 o_ready SHALL be 0 in LO, HI and DONE; i_valid in those states is ignored and does not affect captured operands.
REQ-027 o_valid SHALL be 1 only in DONE.
REQ-028 Latency: o_valid rises exactly 3 cycles after the accepting edge. Minimum initiation interval: 4 cycles, with i_ready held 1.
REQ-029 o_add_a, o_add_b and o_add_cin SHALL be 0 in IDLE and DONE.
REQ-030 o_sum, o_cout and o_ovf SHALL retain the last result in IDLE until overwritten by the next LO/HI.
REQ-031 Arithmetic SHALL be modulo 2^64; the carry out of the low half propagates only through carry_mid.

Reset
REQ-032 While i_rst_n=0: state=IDLE; o_sum=0, o_cout=0, o_ovf=0, o_valid=0, carry_mid=0; operand registers=0; o_ready=1 once reset deasserts.
REQ-033 Reset asserted in LO, HI or DONE SHALL abort the operation with no o_valid pulse; the next request after release SHALL complete normally.

Verification
REQ-034 A=0x00000000_FFFFFFFF, B=1, sub=0 -> 3 cycles later o_valid=1, o_sum=0x00000001_00000000, o_cout=0, o_ovf=0; in HI, o_add_cin=1.
REQ-035 A=0x7FFFFFFF_FFFFFFFF, B=1, sub=0 -> o_sum=0x80000000_00000000, o_ovf=1, o_cout=0.
REQ-036 A=5, B=7, sub=1 -> o_sum=0xFFFFFFFF_FFFFFFFE, o_cout=0, o_ovf=0; A=7, B=5, sub=1 -> o_sum=2, o_cout=1.
REQ-037 i_ready held 0 for 5 cycles in DONE with i_valid=1 and changing operands -> o_valid stays 1, o_sum unchanged, o_ready=0; the result is released on the cycle i_ready=1 and the block returns to IDLE.
REQ-038 Reset pulsed during HI of A=B=0xFFFFFFFF_FFFFFFFF -> no o_valid, all outputs 0; a subsequent 3+4 request -> o_sum=7.
REQ-039 Back-to-back requests with i_valid and i_ready held 1 -> accepts spaced exactly 4 cycles apart, each result correct against a 64-bit reference model over 10k random operand/sub pairs.
